// File: rtl/genesis_bus_pkg.sv
// Shared definitions for the Genesis 68k-side bus glue: DMA responder state
// encoding and the default RAM window / open-bus values.
package genesis_bus_pkg;

    localparam logic [23:0] GENESIS_RAM_BASE = 24'hFF0000;
    localparam logic [15:0] OPEN_BUS_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BUS_REQ,
        ST_OWNED,
        ST_READ,
        ST_ACKED,
        ST_RELEASE
    } vbus_state_t;

endpackage

// File: rtl/vdp_vbus_responder.sv
// Responder end of the VDP 68k-bus DMA port. Takes the 68k bus via BR/BG when
// the VDP asks for it, then serves each VBUS_SEL word read from the 68k work
// RAM (or returns open-bus data outside the RAM window) with VBUS_DTACK_N.
// Read-only: VDP DMA never writes through this port.
module vdp_vbus_responder
    import genesis_bus_pkg::*;
#(
    parameter int          MEM_AW      = 12,
    parameter logic [23:0] MEM_BASE    = GENESIS_RAM_BASE,
    parameter int          MEM_LATENCY = 1,
    parameter logic [15:0] OPEN_BUS    = OPEN_BUS_DEFAULT
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              VBUS_DMA_REQ,
    output logic              VBUS_DMA_ACK,
    input  logic              VBUS_SEL,
    input  logic [23:0]       VBUS_ADDR,
    input  logic              VBUS_UDS_N,
    input  logic              VBUS_LDS_N,
    output logic [15:0]       VBUS_DATA,
    output logic              VBUS_DTACK_N,
    output logic              M68_BR_N,
    input  logic              M68_BG_N,
    input  logic              M68_AS_N,
    output logic              MEM_EN,
    output logic [MEM_AW-1:0] MEM_ADDR,
    input  logic [15:0]       MEM_DO
);

    localparam int                CNT_W     = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0]  LAT_CNT   = CNT_W'(MEM_LATENCY);
    localparam logic [24:0]       WIN_BYTES = 25'd1 << (MEM_AW + 1);

    vbus_state_t       state, state_nxt;
    logic [CNT_W-1:0]  lat_cnt, lat_cnt_nxt;
    logic              ack_nxt;
    logic              dtack_n_nxt;
    logic [15:0]       data_nxt;
    logic              br_n_nxt;
    logic              mem_en_nxt;
    logic [MEM_AW-1:0] mem_addr_nxt;

    logic [23:0]       win_off;
    logic              in_win;

    // Byte strobes are irrelevant (full words are always returned) and bit 0
    // of the byte address never selects anything.
    logic unused_inputs;
    assign unused_inputs = ^{VBUS_UDS_N, VBUS_LDS_N, VBUS_ADDR[0]};

    // Window decode: one 24-bit subtract, in window when above the base and
    // the offset stays inside the RAM size (no wrap into the window).
    assign win_off = VBUS_ADDR - MEM_BASE;
    assign in_win  = (VBUS_ADDR >= MEM_BASE) && ({1'b0, win_off} < WIN_BYTES);

    // State and every output are registered; reset returns all to idle values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= ST_IDLE;
            lat_cnt      <= '0;
            VBUS_DMA_ACK <= 1'b0;
            VBUS_DTACK_N <= 1'b1;
            VBUS_DATA    <= '0;
            M68_BR_N     <= 1'b1;
            MEM_EN       <= 1'b0;
            MEM_ADDR     <= '0;
        end else begin
            state        <= state_nxt;
            lat_cnt      <= lat_cnt_nxt;
            VBUS_DMA_ACK <= ack_nxt;
            VBUS_DTACK_N <= dtack_n_nxt;
            VBUS_DATA    <= data_nxt;
            M68_BR_N     <= br_n_nxt;
            MEM_EN       <= mem_en_nxt;
            MEM_ADDR     <= mem_addr_nxt;
        end
    end

    // Next-state and next-output logic; outputs hold unless a transition
    // changes them, MEM_EN defaults low so it only ever pulses for one cycle.
    always_comb begin
        state_nxt    = state;
        lat_cnt_nxt  = lat_cnt;
        ack_nxt      = VBUS_DMA_ACK;
        dtack_n_nxt  = VBUS_DTACK_N;
        data_nxt     = VBUS_DATA;
        br_n_nxt     = M68_BR_N;
        mem_en_nxt   = 1'b0;
        mem_addr_nxt = MEM_ADDR;

        case (state)
            ST_IDLE: begin
                if (VBUS_DMA_REQ) begin
                    state_nxt = ST_BUS_REQ;
                    br_n_nxt  = 1'b0;
                end
            end

            ST_BUS_REQ: begin
                // Grant only counts once the 68k has also finished its cycle.
                if (!VBUS_DMA_REQ) begin
                    state_nxt = ST_RELEASE;
                    ack_nxt   = 1'b0;
                    br_n_nxt  = 1'b1;
                end else if (!M68_BG_N && M68_AS_N) begin
                    state_nxt = ST_OWNED;
                    ack_nxt   = 1'b1;
                end
            end

            ST_OWNED: begin
                lat_cnt_nxt = '0;
                // A pending select takes priority over a dropped request.
                if (VBUS_SEL) begin
                    if (in_win) begin
                        state_nxt    = ST_READ;
                        mem_en_nxt   = 1'b1;
                        mem_addr_nxt = win_off[MEM_AW:1];
                    end else begin
                        state_nxt   = ST_ACKED;
                        data_nxt    = OPEN_BUS;
                        dtack_n_nxt = 1'b0;
                    end
                end else if (!VBUS_DMA_REQ) begin
                    state_nxt = ST_RELEASE;
                    ack_nxt   = 1'b0;
                    br_n_nxt  = 1'b1;
                end
            end

            ST_READ: begin
                // Request changes are ignored here; the read always completes.
                if (lat_cnt == LAT_CNT) begin
                    state_nxt   = ST_ACKED;
                    data_nxt    = MEM_DO;
                    dtack_n_nxt = 1'b0;
                    lat_cnt_nxt = '0;
                end else begin
                    lat_cnt_nxt = lat_cnt + CNT_W'(1);
                end
            end

            ST_ACKED: begin
                // Leaving only on SEL low guarantees a held SEL is served once.
                if (!VBUS_SEL) begin
                    dtack_n_nxt = 1'b1;
                    if (VBUS_DMA_REQ) begin
                        state_nxt = ST_OWNED;
                    end else begin
                        state_nxt = ST_RELEASE;
                        ack_nxt   = 1'b0;
                        br_n_nxt  = 1'b1;
                    end
                end
            end

            ST_RELEASE: begin
                // One idle cycle keeps BR_N high for at least a cycle.
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vdp_vbus_responder.sv
// Bench for vdp_vbus_responder: bus acquisition, in-window and open-bus reads
// against a RAM model, request drop mid-read, back-to-back reads and reset.
module tb_vdp_vbus_responder;
    import genesis_bus_pkg::*;

    localparam int          AW   = 12;
    localparam logic [23:0] BASE = 24'hFF0000;
    localparam int          LAT  = 1;

    logic          clk;
    logic          rst_n;
    logic          req;
    logic          ack;
    logic          sel;
    logic [23:0]   vaddr;
    logic          uds_n;
    logic          lds_n;
    logic [15:0]   vdata;
    logic          dtack_n;
    logic          br_n;
    logic          bg_n;
    logic          as_n;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_do;

    int checks   = 0;
    int failures = 0;

    logic [15:0] ram [0:(1<<AW)-1];
    logic [15:0] exp_q [$];

    vdp_vbus_responder #(
        .MEM_AW      (AW),
        .MEM_BASE    (BASE),
        .MEM_LATENCY (LAT),
        .OPEN_BUS    (16'hFFFF)
    ) dut (
        .CLK          (clk),
        .RST_N        (rst_n),
        .VBUS_DMA_REQ (req),
        .VBUS_DMA_ACK (ack),
        .VBUS_SEL     (sel),
        .VBUS_ADDR    (vaddr),
        .VBUS_UDS_N   (uds_n),
        .VBUS_LDS_N   (lds_n),
        .VBUS_DATA    (vdata),
        .VBUS_DTACK_N (dtack_n),
        .M68_BR_N     (br_n),
        .M68_BG_N     (bg_n),
        .M68_AS_N     (as_n),
        .MEM_EN       (mem_en),
        .MEM_ADDR     (mem_addr),
        .MEM_DO       (mem_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM with one cycle of read latency.
    initial mem_do = 16'h0000;
    always @(posedge clk) if (mem_en) mem_do <= ram[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acquire();
        req  = 1'b1;
        bg_n = 1'b0;
        as_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic release_bus();
        req = 1'b0;
        sel = 1'b0;
        tick();
        tick();
        bg_n = 1'b1;
    endtask

    // Drives one read; expected data is queued at drive time and popped when
    // DTACK appears (or the wait expires).
    task automatic issue_read(input logic [23:0] addr, input bit drop_req,
                              output int edges, output logic [15:0] act,
                              output logic [15:0] expv, output int en_cnt,
                              output logic [AW-1:0] en_addr, output bit win,
                              output bit timeout);
        logic [23:0] off;
        off = addr - BASE;
        win = (addr >= BASE) && (off < 24'h002000);
        if (win) exp_q.push_back(ram[off[AW:1]]);
        else     exp_q.push_back(16'hFFFF);
        sel     = 1'b1;
        vaddr   = addr;
        edges   = 0;
        en_cnt  = 0;
        en_addr = '0;
        timeout = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (drop_req && edges == 1) req = 1'b0;
            if (mem_en) begin
                en_cnt++;
                en_addr = mem_addr;
            end
            if (!dtack_n) begin
                timeout = 1'b0;
                break;
            end
        end
        act  = vdata;
        expv = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 1'b0; sel = 1'b0; vaddr = '0; uds_n = 1'b1; lds_n = 1'b1;
        bg_n = 1'b1; as_n = 1'b1;
        #12;
        checks++;
        if ({ack, dtack_n, br_n, mem_en} !== 4'b0110 || vdata !== 16'h0000 || mem_addr !== '0) begin
            failures++;
            $display("FAIL reset_values: ack=%b dtack_n=%b br_n=%b mem_en=%b data=%h addr=%h", ack, dtack_n, br_n, mem_en, vdata, mem_addr);
        end
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (br_n !== 1'b1 || ack !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_req: br_n=%b ack=%b want br_n=1 ack=0", br_n, ack);
        end
    endtask

    task automatic test_grant();
        req = 1'b1; bg_n = 1'b1; as_n = 1'b1;
        tick();
        checks++;
        if (br_n !== 1'b0 || ack !== 1'b0) begin
            failures++;
            $display("FAIL br_after_req: br_n=%b ack=%b want br_n=0 ack=0", br_n, ack);
        end
        tick(); tick(); tick();
        checks++;
        if (ack !== 1'b0) begin
            failures++;
            $display("FAIL ack_before_grant: got %b want 0", ack);
        end
        bg_n = 1'b0;
        tick();
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL ack_after_grant: got %b want 1", ack);
        end
    endtask

    task automatic test_release();
        req = 1'b0;
        tick();
        checks++;
        if (ack !== 1'b0 || br_n !== 1'b1) begin
            failures++;
            $display("FAIL release_entry: ack=%b br_n=%b want 0/1", ack, br_n);
        end
        req = 1'b1;
        tick();
        checks++;
        if (br_n !== 1'b1) begin
            failures++;
            $display("FAIL br_gap: br_n=%b want 1", br_n);
        end
        tick();
        checks++;
        if (br_n !== 1'b0) begin
            failures++;
            $display("FAIL re_request: br_n=%b want 0", br_n);
        end
        req = 1'b0;
        tick(); tick();
        bg_n = 1'b1;
    endtask

    task automatic test_as_busy();
        req = 1'b1; bg_n = 1'b0; as_n = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (ack !== 1'b0) begin
                failures++;
                $display("FAIL ack_while_as: cycle %0d got %b want 0", i, ack);
            end
        end
        as_n = 1'b1;
        tick();
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL ack_after_as: got %b want 1", ack);
        end
    endtask

    task automatic test_ram_read();
        int edges, en_cnt; logic [15:0] act, expv; logic [AW-1:0] en_addr; bit win, to;
        issue_read(24'hFF0010, 1'b0, edges, act, expv, en_cnt, en_addr, win, to);
        checks++;
        if (to || edges !== 2 + LAT) begin
            failures++;
            $display("FAIL ram_latency: edges=%0d timeout=%0d want %0d", edges, to, 2 + LAT);
        end
        checks++;
        if (act !== 16'hBEEF || expv !== 16'hBEEF) begin
            failures++;
            $display("FAIL ram_data: got %h want %h", act, expv);
        end
        checks++;
        if (en_cnt !== 1 || en_addr !== 12'd8) begin
            failures++;
            $display("FAIL ram_mem_en: pulses=%0d addr=%0d want 1 pulse at 8", en_cnt, en_addr);
        end
        tick(); tick();
        checks++;
        if (dtack_n !== 1'b0 || vdata !== 16'hBEEF) begin
            failures++;
            $display("FAIL ram_hold: dtack_n=%b data=%h want 0/BEEF", dtack_n, vdata);
        end
        sel = 1'b0;
        tick();
        checks++;
        if (dtack_n !== 1'b1 || ack !== 1'b1) begin
            failures++;
            $display("FAIL ram_end: dtack_n=%b ack=%b want 1/1", dtack_n, ack);
        end
    endtask

    task automatic test_open_bus();
        int edges, en_cnt; logic [15:0] act, expv; logic [AW-1:0] en_addr; bit win, to;
        issue_read(24'h000400, 1'b0, edges, act, expv, en_cnt, en_addr, win, to);
        checks++;
        if (to || edges !== 1 || en_cnt !== 0) begin
            failures++;
            $display("FAIL open_timing: edges=%0d mem_en=%0d timeout=%0d want 1/0", edges, en_cnt, to);
        end
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL open_data: got %h want %h", act, expv);
        end
        sel = 1'b0;
        tick();
        checks++;
        if (dtack_n !== 1'b1) begin
            failures++;
            $display("FAIL open_end: dtack_n=%b want 1", dtack_n);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] addrs [6] = '{24'hFF0000, 24'hFF1FFE, 24'hFF2000,
                                   24'hFEFFFE, 24'hFF0011, 24'hFF0A42};
        int edges, en_cnt; logic [15:0] act, expv; logic [AW-1:0] en_addr; bit win, to;
        logic [23:0] off;
        for (int k = 0; k < 6; k++) begin
            issue_read(addrs[k], 1'b0, edges, act, expv, en_cnt, en_addr, win, to);
            off = addrs[k] - BASE;
            checks++;
            if (to || edges !== (win ? 2 + LAT : 1) || en_cnt !== (win ? 1 : 0)) begin
                failures++;
                $display("FAIL b2b_timing: addr=%h edges=%0d mem_en=%0d timeout=%0d", addrs[k], edges, en_cnt, to);
            end
            checks++;
            if (act !== expv || (win && en_addr !== off[AW:1])) begin
                failures++;
                $display("FAIL b2b_data: addr=%h got %h/%h want %h/%h", addrs[k], act, en_addr, expv, off[AW:1]);
            end
            sel = 1'b0;
            tick();
            checks++;
            if (dtack_n !== 1'b1) begin
                failures++;
                $display("FAIL b2b_end: addr=%h dtack_n=%b want 1", addrs[k], dtack_n);
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size());
        end
    endtask

    task automatic test_req_drop_in_read();
        int edges, en_cnt; logic [15:0] act, expv; logic [AW-1:0] en_addr; bit win, to;
        issue_read(24'hFF0100, 1'b1, edges, act, expv, en_cnt, en_addr, win, to);
        checks++;
        if (to || act !== expv || edges !== 2 + LAT) begin
            failures++;
            $display("FAIL drop_read: data=%h edges=%0d timeout=%0d want %h", act, edges, to, expv);
        end
        checks++;
        if (ack !== 1'b1 || br_n !== 1'b0) begin
            failures++;
            $display("FAIL drop_still_owned: ack=%b br_n=%b want 1/0", ack, br_n);
        end
        sel = 1'b0;
        tick();
        checks++;
        if (dtack_n !== 1'b1 || ack !== 1'b0 || br_n !== 1'b1) begin
            failures++;
            $display("FAIL drop_release: dtack_n=%b ack=%b br_n=%b want 1/0/1", dtack_n, ack, br_n);
        end
        tick();
        bg_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        int edges, en_cnt; logic [15:0] act, expv; logic [AW-1:0] en_addr; bit win, to;
        acquire();
        issue_read(24'hFF0020, 1'b0, edges, act, expv, en_cnt, en_addr, win, to);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dtack_n !== 1'b1 || ack !== 1'b0 || br_n !== 1'b1 || vdata !== 16'h0000) begin
            failures++;
            $display("FAIL async_reset: dtack_n=%b ack=%b br_n=%b data=%h want 1/0/1/0000", dtack_n, ack, br_n, vdata);
        end
        sel = 1'b0; req = 1'b0; bg_n = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        acquire();
        checks++;
        if (ack !== 1'b1) begin
            failures++;
            $display("FAIL restart_ack: got %b want 1", ack);
        end
        issue_read(24'hFF0010, 1'b0, edges, act, expv, en_cnt, en_addr, win, to);
        checks++;
        if (to || act !== expv || edges !== 2 + LAT) begin
            failures++;
            $display("FAIL restart_read: data=%h edges=%0d timeout=%0d want %h", act, edges, to, expv);
        end
        sel = 1'b0;
        tick();
        release_bus();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 16'(i * 37) ^ 16'hC3A5;
        ram[8] = 16'hBEEF;

        test_reset();
        test_grant();
        test_release();
        test_as_busy();
        test_ram_read();
        test_open_bus();
        test_back_to_back();
        test_req_drop_in_read();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
